// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the pipelined ALU: op-code encodings and FSM states.
// Optional SLL support is selected with the ALU_PIPE_SHIFT_EN macro.
package alu_pipe_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle of the pipelined ALU.
// master: operand producer / result consumer side. slave: the ALU.
interface alu_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carryout;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, in1, in2, op, out_ready,
        input  in_ready, out_valid, result, carryout, overflow, zero
    );

    modport slave (
        input  in_valid, in1, in2, op, out_ready,
        output in_ready, out_valid, result, carryout, overflow, zero
    );
endinterface

// File: rtl/alu_pipe_core.sv
// Combinational logic/adder unit for all single-cycle ALU operations.
// SUB and SLT share the adder as in1 + ~in2 + 1; SLL yields zero here
// (the shifter lives in alu_pipe).
module alu_core
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             ovf
);
    logic             sub_s;
    logic [WIDTH-1:0] b_s;
    logic [WIDTH:0]   sum_s;
    logic             v_s;

    assign sub_s = (op == ALU_SUB) || (op == ALU_SLT);
    assign b_s   = sub_s ? ~in2 : in2;
    assign sum_s = {1'b0, in1} + {1'b0, b_s} + {{WIDTH{1'b0}}, sub_s};
    // Signed overflow: both adder inputs share a sign that the sum does not.
    assign v_s   = (in1[WIDTH-1] == b_s[WIDTH-1]) && (sum_s[WIDTH-1] != in1[WIDTH-1]);

    // Select the operation result and its flags.
    always_comb begin
        res  = '0;
        cout = 1'b0;
        ovf  = 1'b0;
        case (op)
            ALU_AND: res = in1 & in2;
            ALU_OR:  res = in1 | in2;
            ALU_XOR: res = in1 ^ in2;
            ALU_NOR: res = ~(in1 | in2);
            ALU_ADD, ALU_SUB: begin
                res  = sum_s[WIDTH-1:0];
                cout = sum_s[WIDTH];
                ovf  = v_s;
            end
            ALU_SLT: begin
                res  = {{(WIDTH-1){1'b0}}, sum_s[WIDTH-1] ^ v_s};
                cout = sum_s[WIDTH];
            end
            ALU_SLL: res = '0;
            default: res = '0;
        endcase
    end
endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes on both sides.
// Define ALU_PIPE_SHIFT_EN to build the multi-cycle SLL (SHIFT state and
// counter); otherwise op=101 completes in one cycle with a zero result.
// reset asserts asynchronously and is expected to be released synchronously.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    alu_pipe_if.slave  bus
);
    localparam int SH_W = $clog2(WIDTH);

    logic             idle_s;
    logic             accept_s;
    logic             start_shift_s;
    logic             shift_done_s;
    logic [WIDTH-1:0] shift_res_s;
    logic [WIDTH-1:0] single_res_s;
    logic [WIDTH-1:0] core_res_s;
    logic             core_cout_s;
    logic             core_ovf_s;

    logic [WIDTH-1:0] result_q, result_d;
    logic             out_valid_q, out_valid_d;
    logic             carryout_q, carryout_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .in1  (bus.in1),
        .in2  (bus.in2),
        .op   (bus.op),
        .res  (core_res_s),
        .cout (core_cout_s),
        .ovf  (core_ovf_s)
    );

    assign bus.in_ready = idle_s && (!out_valid_q || bus.out_ready);
    assign accept_s     = bus.in_valid && bus.in_ready;

`ifdef ALU_PIPE_SHIFT_EN
    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [SH_W-1:0]  cnt_q, cnt_d;
    logic [SH_W-1:0]  amt_s;

    assign amt_s        = bus.in2[SH_W-1:0];
    assign idle_s       = (state_q == S_IDLE);
    // A zero-amount SLL is handled as a single-cycle pass-through of in1.
    assign single_res_s = (bus.op == ALU_SLL) ? bus.in1 : core_res_s;

    // Shift FSM: latch operand/count on start, shift one bit per cycle.
    always_comb begin
        state_d       = state_q;
        sh_d          = sh_q;
        cnt_d         = cnt_q;
        start_shift_s = 1'b0;
        shift_done_s  = 1'b0;
        shift_res_s   = {sh_q[WIDTH-2:0], 1'b0};
        case (state_q)
            S_IDLE: begin
                if (accept_s && (bus.op == ALU_SLL) && (amt_s != '0)) begin
                    start_shift_s = 1'b1;
                    state_d       = S_SHIFT;
                    sh_d          = bus.in1;
                    cnt_d         = amt_s;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                sh_d  = shift_res_s;
                cnt_d = cnt_q - SH_W'(1);
                if (cnt_q == SH_W'(1)) begin
                    shift_done_s = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Shift FSM state, working operand and remaining count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    assign idle_s        = 1'b1;
    assign start_shift_s = 1'b0;
    assign shift_done_s  = 1'b0;
    assign shift_res_s   = '0;
    assign single_res_s  = core_res_s;
`endif

    // Output bundle: hold under backpressure, load on accept or shift completion.
    always_comb begin
        out_valid_d = out_valid_q && !bus.out_ready;
        result_d    = result_q;
        carryout_d  = carryout_q;
        overflow_d  = overflow_q;
        if (shift_done_s) begin
            out_valid_d = 1'b1;
            result_d    = shift_res_s;
            carryout_d  = 1'b0;
            overflow_d  = 1'b0;
        end else if (accept_s && !start_shift_s) begin
            out_valid_d = 1'b1;
            result_d    = single_res_s;
            carryout_d  = core_cout_s;
            overflow_d  = core_ovf_s;
        end else begin
            out_valid_d = out_valid_q && !bus.out_ready;
        end
        zero_d = (result_d == '0);
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carryout_q  <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b1;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            carryout_q  <= carryout_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.carryout  = carryout_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=32) with hand-computed expectations.
// SLL expectations follow the ALU_PIPE_SHIFT_EN setting of the build.
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    logic clk;
    logic reset;
    int   vec_cnt;
    int   miss_cnt;

    alu_pipe_if #(.WIDTH(32)) bus ();

    alu_pipe #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.in1      = a;
        bus.in2      = b;
    endtask

    task automatic check_res(input string tag, input logic [31:0] r,
                             input logic c, input logic v, input logic z);
        chk({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({tag, ".result"}, bus.result, r);
        chk({tag, ".carry"}, {31'd0, bus.carryout}, {31'd0, c});
        chk({tag, ".ovf"}, {31'd0, bus.overflow}, {31'd0, v});
        chk({tag, ".zero"}, {31'd0, bus.zero}, {31'd0, z});
    endtask

    initial begin
        vec_cnt       = 0;
        miss_cnt      = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = 3'b000;
        bus.in1       = 32'd0;
        bus.in2       = 32'd0;
        bus.out_ready = 1'b1;
        #1;
        chk("rst.valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst.result", bus.result, 32'd0);
        chk("rst.zero", {31'd0, bus.zero}, 32'd1);
        chk("rst.carry", {31'd0, bus.carryout}, 32'd0);
        chk("rst.ovf", {31'd0, bus.overflow}, 32'd0);
        step();
        step();
        reset = 1'b0;

        // Back-to-back single-cycle ops with out_ready held high
        drive(ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
        chk("add_wrap.in_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        check_res("add_wrap", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        drive(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        step();
        check_res("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        drive(ALU_SUB, 32'h0000_0005, 32'h0000_0007);
        step();
        check_res("sub", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        drive(ALU_SLT, 32'hFFFF_FFFF, 32'h0000_0001);
        step();
        check_res("slt_neg", 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        drive(ALU_SLT, 32'h8000_0000, 32'h7FFF_FFFF);
        step();
        check_res("slt_ovf", 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        drive(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
        step();
        check_res("and", 32'hF000_F000, 1'b0, 1'b0, 1'b0);
        drive(ALU_OR, 32'h0F0F_0000, 32'h0000_00F0);
        step();
        check_res("or", 32'h0F0F_00F0, 1'b0, 1'b0, 1'b0);
        drive(ALU_XOR, 32'hA5A5_A5A5, 32'hFFFF_0000);
        step();
        check_res("xor", 32'h5A5A_A5A5, 1'b0, 1'b0, 1'b0);
        drive(ALU_NOR, 32'h0000_0000, 32'h0000_0000);
        step();
        check_res("nor_ones", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        drive(ALU_NOR, 32'hFFFF_0000, 32'h0000_FFFF);
        step();
        check_res("nor_zero", 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        step();
        chk("drain.valid", {31'd0, bus.out_valid}, 32'd0);

        // Backpressure: result held, no new accept until out_ready rises
        bus.out_ready = 1'b0;
        drive(ALU_AND, 32'h1234_5678, 32'h0000_FFFF);
        step();
        check_res("bp_and", 32'h0000_5678, 1'b0, 1'b0, 1'b0);
        drive(ALU_OR, 32'h0000_0001, 32'h0000_0002);
        for (int i = 0; i < 3; i++) begin
            chk("bp.in_ready", {31'd0, bus.in_ready}, 32'd0);
            step();
            chk("bp.result_stable", bus.result, 32'h0000_5678);
            chk("bp.valid_stable", {31'd0, bus.out_valid}, 32'd1);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release.in_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        check_res("bp_or", 32'h0000_0003, 1'b0, 1'b0, 1'b0);

        // Reset while a result is pending clears outputs without a clock edge
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        step();
        chk("pre_rst.valid", {31'd0, bus.out_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst.valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst.zero", {31'd0, bus.zero}, 32'd1);
        chk("mid_rst.result", bus.result, 32'd0);
        step();
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        drive(ALU_ADD, 32'h0000_0002, 32'h0000_0003);
        chk("post_rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        check_res("post_rst_add", 32'h0000_0005, 1'b0, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        step();

`ifdef ALU_PIPE_SHIFT_EN
        // SLL by 4: in_ready low while shifting, result after 4 cycles
        drive(ALU_SLL, 32'h0000_0003, 32'h0000_0004);
        step();
        bus.in_valid = 1'b0;
        chk("sll4.in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("sll4.valid_low", {31'd0, bus.out_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("sll4.in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("sll4.valid_low", {31'd0, bus.out_valid}, 32'd0);
        end
        step();
        check_res("sll4", 32'h0000_0030, 1'b0, 1'b0, 1'b0);
        chk("sll4_done.in_ready", {31'd0, bus.in_ready}, 32'd1);
        drive(ALU_SLL, 32'hDEAD_BEEF, 32'h0000_0000);
        step();
        check_res("sll0", 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        drive(ALU_SLL, 32'h8000_0001, 32'd33);
        step();
        bus.in_valid = 1'b0;
        chk("sll33.valid_low", {31'd0, bus.out_valid}, 32'd0);
        chk("sll33.in_ready", {31'd0, bus.in_ready}, 32'd0);
        step();
        check_res("sll33", 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        step();

        // Reset during SHIFT aborts the shift; next op accepted right after release
        drive(ALU_SLL, 32'h0000_0001, 32'h0000_0008);
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        chk("shift_rst.valid", {31'd0, bus.out_valid}, 32'd0);
        step();
        reset = 1'b0;
        drive(ALU_ADD, 32'h0000_0010, 32'h0000_0020);
        chk("shift_rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        check_res("shift_rst_add", 32'h0000_0030, 1'b0, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("shift_rst.no_pulse", {31'd0, bus.out_valid}, 32'd0);
        end
`else
        // Without the shifter SLL completes in one cycle with a zero result
        drive(ALU_SLL, 32'h0000_0003, 32'h0000_0004);
        step();
        check_res("sll_off", 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        drive(ALU_SLL, 32'hDEAD_BEEF, 32'h0000_0000);
        step();
        check_res("sll_off0", 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        step();
        chk("sll_off.drain", {31'd0, bus.out_valid}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
